range_sum_ctrl: RTL and testbench

Sequential front-end for the combinational nibble range-summer (eight 4-bit operands, two 3-bit index bounds, 8-bit sum). It loads eight nibbles serially into a register array and accepts range queries over a valid/ready handshake. It drives the registered operand bus and bounds into the summer, captures the summer's 8-bit result one cycle later, and returns it with an element count over a second valid/ready handshake.

---
 rtl/range_sum_ctrl.sv | 124 ++++++++++++
 tb/tb_range_sum_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/range_sum_ctrl.sv
// Sequential front-end for the combinational nibble range-summer.
// Serial array load, range query handshake, one-cycle evaluate, held result.
module range_sum_ctrl #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [DATA_W-1:0]         ld_data,
    input  logic                      ld_clear,
    input  logic                      q_valid,
    output logic                      q_ready,
    input  logic [$clog2(DEPTH)-1:0]  q_a,
    input  logic [$clog2(DEPTH)-1:0]  q_b,
    output logic [DATA_W*DEPTH-1:0]   Iin,
    output logic [$clog2(DEPTH)-1:0]  M,
    output logic [$clog2(DEPTH)-1:0]  m,
    input  logic [7:0]                sum_in,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [7:0]                res_sum,
    output logic [$clog2(DEPTH):0]    res_cnt
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_ARMED,
        S_EVAL,
        S_RESP
    } state_t;

    state_t              state_q;
    logic [IW-1:0]       wptr_q;
    logic [DATA_W-1:0]   arr_q [DEPTH];
    logic [IW-1:0]       M_q;
    logic [IW-1:0]       m_q;
    logic [7:0]          sum_q;
    logic [CW-1:0]       cnt_q;

    logic [IW-1:0]       diff_d;
    logic [CW-1:0]       cnt_d;
    logic                ld_fire;
    logic                q_fire;

    assign ld_ready  = (state_q == S_LOAD);
    assign q_ready   = (state_q == S_ARMED);
    assign res_valid = (state_q == S_RESP);

    assign ld_fire = ld_valid & ld_ready;
    assign q_fire  = q_valid & q_ready;

    always_comb begin
        diff_d = '0;
        if (q_a >= q_b) diff_d = q_a - q_b;
        else            diff_d = q_b - q_a;
        cnt_d = {1'b0, diff_d} + CW'(1);
    end

    always_comb begin
        Iin = '0;
        for (int k = 0; k < DEPTH; k++) begin
            Iin[k*DATA_W +: DATA_W] = arr_q[k];
        end
    end

    assign M       = M_q;
    assign m       = m_q;
    assign res_sum = sum_q;
    assign res_cnt = cnt_q;

    // ld_clear overrides every state and swallows any same-cycle handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            wptr_q  <= '0;
            M_q     <= '0;
            m_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                arr_q[k] <= '0;
            end
        end else if (ld_clear) begin
            state_q <= S_LOAD;
            wptr_q  <= '0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    if (ld_fire) begin
                        arr_q[wptr_q] <= ld_data;
                        wptr_q        <= wptr_q + IW'(1);
                        if (wptr_q == IW'(DEPTH - 1)) begin
                            state_q <= S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (q_fire) begin
                        M_q     <= q_a;
                        m_q     <= q_b;
                        cnt_q   <= cnt_d;
                        state_q <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    sum_q   <= sum_in;
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    if (res_ready) begin
                        state_q <= S_ARMED;
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_range_sum_ctrl.sv
// Bench for range_sum_ctrl: transaction-level reference model compared
// every cycle, plus directed queries with hand-computed results.
module tb_range_sum_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [3:0]  ld_data = '0;
    logic        ld_clear = 1'b0;
    logic        q_valid = 1'b0;
    logic        q_ready;
    logic [2:0]  q_a = '0;
    logic [2:0]  q_b = '0;
    logic [31:0] Iin;
    logic [2:0]  M;
    logic [2:0]  m;
    logic [7:0]  sum_in;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res_sum;
    logic [3:0]  res_cnt;

    int checks = 0;
    int errors = 0;

    range_sum_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_clear(ld_clear),
        .q_valid(q_valid), .q_ready(q_ready),
        .q_a(q_a), .q_b(q_b),
        .Iin(Iin), .M(M), .m(m), .sum_in(sum_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cnt(res_cnt)
    );

    always #5 clk = ~clk;

    // The external summer the controller feeds.
    always @* begin
        int lo, hi, s;
        lo = (M < m) ? int'(M) : int'(m);
        hi = (M < m) ? int'(m) : int'(M);
        s = 0;
        for (int k = lo; k <= hi; k++) s += int'(Iin[4*k +: 4]);
        sum_in = 8'(s);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what has been loaded, and where the transaction stands.
    int  mem [8];
    int  nload;
    bit  loading, evaluating, responding;
    int  ea, eb, esum, ecnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (mem[i]) mem[i] = 0;
            nload = 0; loading = 1; evaluating = 0; responding = 0;
            ea = 0; eb = 0; esum = 0; ecnt = 0;
        end else if (ld_clear) begin
            loading = 1; nload = 0; evaluating = 0; responding = 0;
        end else if (loading) begin
            if (ld_valid) begin
                mem[nload] = int'(ld_data);
                nload++;
                if (nload == 8) begin
                    nload = 0;
                    loading = 0;
                end
            end
        end else if (evaluating) begin
            int lo, hi;
            lo = (ea < eb) ? ea : eb;
            hi = (ea < eb) ? eb : ea;
            esum = 0;
            for (int k = lo; k <= hi; k++) esum += mem[k];
            evaluating = 0;
            responding = 1;
        end else if (responding) begin
            if (res_ready) responding = 0;
        end else if (q_valid) begin
            ea = int'(q_a);
            eb = int'(q_b);
            ecnt = ((ea > eb) ? ea - eb : eb - ea) + 1;
            evaluating = 1;
        end
    end

    always @(negedge clk) begin
        int packed_exp;
        packed_exp = 0;
        for (int k = 0; k < 8; k++) packed_exp |= (mem[k] & 15) << (4 * k);
        chk("ld_ready", int'(ld_ready), int'(loading));
        chk("q_ready", int'(q_ready),
            int'(!loading && !evaluating && !responding));
        chk("res_valid", int'(res_valid), int'(responding));
        chk("Iin", int'(Iin), packed_exp);
        chk("M", int'(M), ea);
        chk("m", int'(m), eb);
        chk("res_sum", int'(res_sum), esum);
        chk("res_cnt", int'(res_cnt), ecnt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ld_valid = 0; ld_clear = 0; q_valid = 0; res_ready = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load_word(input int d);
        ld_valid = 1'b1;
        ld_data  = 4'(d);
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic query(input int a, input int b, input int xs, input int xc,
                         input bit release_now);
        int n;
        q_valid = 1'b1;
        q_a = 3'(a);
        q_b = 3'(b);
        tick();
        q_valid = 1'b0;
        n = 1;
        while (!res_valid && n < 10) begin
            tick();
            n++;
        end
        chk("q_latency", n, 2);
        chk("q_sum", int'(res_sum), xs);
        chk("q_cnt", int'(res_cnt), xc);
        if (release_now) begin
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            chk("q_ready_after_release", int'(q_ready), 1);
        end
    endtask

    initial begin
        do_reset();
        chk("rst_ld_ready", int'(ld_ready), 1);
        chk("rst_q_ready", int'(q_ready), 0);
        chk("rst_Iin", int'(Iin), 0);

        for (int i = 1; i <= 8; i++) load_word(i);
        chk("armed_after_8", int'(q_ready), 1);
        query(0, 7, 36, 8, 1);
        query(5, 2, 18, 4, 1);
        query(3, 3, 4, 1, 1);

        ld_clear = 1'b1;
        tick();
        ld_clear = 1'b0;
        for (int i = 0; i < 8; i++) load_word(15);
        query(7, 0, 120, 8, 0);

        // Held response: data stable, new queries ignored.
        for (int i = 0; i < 5; i++) begin
            q_valid = (i % 2 == 0);
            q_a = 3'd1;
            q_b = 3'd1;
            tick();
            chk("hold_valid", int'(res_valid), 1);
            chk("hold_sum", int'(res_sum), 120);
            chk("hold_cnt", int'(res_cnt), 8);
            chk("hold_q_ready", int'(q_ready), 0);
        end
        q_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("release_q_ready", int'(q_ready), 1);

        query(2, 6, 75, 5, 0);
        ld_clear = 1'b1;
        res_ready = 1'b1;
        tick();
        ld_clear = 1'b0;
        res_ready = 1'b0;
        chk("clr_ld_ready", int'(ld_ready), 1);
        chk("clr_res_valid", int'(res_valid), 0);
        for (int i = 0; i < 8; i++) load_word(i);
        query(0, 3, 6, 4, 1);
        query(6, 7, 13, 2, 1);

        // Async reset in the middle of a reload.
        ld_clear = 1'b1;
        tick();
        ld_clear = 1'b0;
        for (int i = 0; i < 4; i++) load_word(9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ld_ready", int'(ld_ready), 1);
        chk("async_Iin", int'(Iin), 0);
        chk("async_res_cnt", int'(res_cnt), 0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) load_word(i + 8);
        chk("seven_not_armed", int'(q_ready), 0);
        load_word(1);
        chk("eight_armed", int'(q_ready), 1);
        chk("fresh_Iin", int'(Iin), 32'h1EDC_BA98);
        query(4, 7, 40, 4, 1);

        // Load words offered while armed must not change the array.
        ld_valid = 1'b1;
        ld_data = 4'd3;
        tick();
        tick();
        ld_valid = 1'b0;
        query(0, 0, 8, 1, 1);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
